bio_gen: RTL and testbench
==========================

Name: bio_gen

Overview:
- Parametrised board-I/O controller; successor to the fixed single-register board I/O block.
- Sits on the internal stb/we/ack bus as one slave.
- Provides register-mapped LEDs and per-digit hex-to-7-segment decoding with blanking.
- Provides debounced push-buttons and synchronised switches, with optional key-press event latching and an interrupt.

Parameters:
- NUM_KEYS, 3: number of active-low push-buttons (1..8).
- NUM_SW, 18: number of slide switches (1..32).
- NUM_LEDG, 9: green LED count (1..32).
- NUM_LEDR, 18: red LED count (1..32).
- NUM_HEX, 8: 7-segment digits (1..8).
- DEBOUNCE_CYCLES, 50000: cycles a synchronised key level must be stable before it is accepted (>=2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- stb  in  1  bus strobe
- we  in  1  write enable
- addr  in  3  word register index
- data_in  in  32  write data
- data_out  out  32  read data
- ack  out  1  bus acknowledge
- irq  out  1  key-event interrupt, level
- led_g  out  NUM_LEDG  green LEDs, active-high
- led_r  out  NUM_LEDR  red LEDs, active-high
- hex_n  out  7*NUM_HEX  segments; digit i at [7i+6:7i], bit order g..a, active-low
- key_n  in  NUM_KEYS  push-buttons, active-low, asynchronous
- sw  in  NUM_SW  switches, asynchronous

Behaviour:
- Reset: one clock (clk); reset asynchronous, active-low (rst_n). While rst_n=0:
  - led_g=0, led_r=0, hex data=0, blank mask=all ones, so hex_n=all ones.
  - Debounced keys=0 (released), debounce counters=0, sync flops=released / 0.
  - Event register=0, irq=0.
- Bus:
  - ack=stb, combinational; every access completes in the same cycle.
  - Writes take effect on the clock edge where stb&we=1.
  - data_out is combinational from addr and is valid whenever stb=1. It is 0 for unmapped addresses and for unused upper bits.
- Register map (addr):
  - 0 LEDG, R/W: bits [NUM_LEDG-1:0].
  - 1 LEDR, R/W: bits [NUM_LEDR-1:0].
  - 2 HEXDATA, R/W: nibble i at [4i+3:4i] drives digit i.
  - 3 HEXBLANK, R/W: bit i=1 blanks digit i (all segments off).
  - 4 KEYS, RO: debounced key state, 1=pressed, bits [NUM_KEYS-1:0].
  - 5 SW, RO: synchronised switches, bits [NUM_SW-1:0].
  - 6 EVENT, R/W1C: sticky press events.
  - 7 IRQEN, R/W: per-key event enable.
  - Writes to RO or unmapped addresses are ignored.
- Hex decode:
  - Standard 0-9, A, b, C, d, E, F glyphs.
  - Output registered: hex_n updates one cycle after a HEXDATA/HEXBLANK write.
- Switch path: 2-flop synchroniser, no debounce. Latency 2 cycles from pin to SW register.
- Key path:
  - 2-flop synchroniser, inverted to active-high, then a per-key debouncer.
  - Debouncer: counter clears whenever the synchronised level equals the debounced state.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the debounced state toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes KEYS.
  - Total latency pin→KEYS = DEBOUNCE_CYCLES+2 cycles.
- Counter width: clog2(DEBOUNCE_CYCLES); no wrap is possible, since it clears at the terminal count.
- Reset mid-debounce: counter discarded; key reads released after reset.

Optional Feature:
- Macro: BIO_GEN_IRQ_EN.
- Defined:
  - A 0→1 transition of debounced key k sets EVENT[k].
  - Writing 1 to EVENT[k] clears it. If a set and a clear occur in the same cycle, set wins.
  - irq is registered: irq = |(EVENT & IRQEN), one cycle after EVENT/IRQEN change.
- Undefined:
  - No edge detector, EVENT and IRQEN registers.
  - Addresses 6-7 read 0 and ignore writes; irq tied 0.

Test Plan:
- Reset, then read addr 0-5 -> all 0 except addr 3 = (1<<NUM_HEX)-1; hex_n all ones; irq=0.
- Write 0x1A5 to addr 0, write 0x76543210 to addr 2, write 0 to addr 3:
  - Read addr 0 = 0x1A5; led_g=9'h1A5.
  - One cycle later digit0 hex_n=7'b1000000 ('0'), digit7=7'b1111000 ('7').
- Key0 low pulse of DEBOUNCE_CYCLES-2 cycles (bench param DEBOUNCE_CYCLES=16) -> KEYS stays 0.
- Key0 held low 40 cycles -> KEYS bit0=1 exactly 18 cycles after the falling pin edge.
- sw=0x2AAAA -> read addr 5 = 0x2AAAA after 2 cycles.
- With BIO_GEN_IRQ_EN, IRQEN=1, key0 press -> EVENT=1 and irq=1.
  - Write 1 to EVENT in the same cycle as a new key0 press edge -> EVENT stays 1.
  - Otherwise the write clears EVENT and irq drops the next cycle.

Source files
------------

// File: rtl/bio_gen.sv
// bio_gen: parametrised board I/O bus slave with LEDs, 7-segment digits, debounced keys and switches.
// Define BIO_GEN_IRQ_EN to add key-press event latching (EVENT/IRQEN registers) and the irq output.
module bio_gen #(
  parameter int NUM_KEYS        = 3,
  parameter int NUM_SW          = 18,
  parameter int NUM_LEDG        = 9,
  parameter int NUM_LEDR        = 18,
  parameter int NUM_HEX         = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stb,
  input  logic                 we,
  input  logic [2:0]           addr,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 ack,
  output logic                 irq,
  output logic [NUM_LEDG-1:0]  led_g,
  output logic [NUM_LEDR-1:0]  led_r,
  output logic [7*NUM_HEX-1:0] hex_n,
  input  logic [NUM_KEYS-1:0]  key_n,
  input  logic [NUM_SW-1:0]    sw
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int HEX_W = 4 * NUM_HEX;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] A_LEDG     = 3'd0;
  localparam logic [2:0] A_LEDR     = 3'd1;
  localparam logic [2:0] A_HEXDATA  = 3'd2;
  localparam logic [2:0] A_HEXBLANK = 3'd3;
  localparam logic [2:0] A_KEYS     = 3'd4;
  localparam logic [2:0] A_SW       = 3'd5;
  localparam logic [2:0] A_EVENT    = 3'd6;
  localparam logic [2:0] A_IRQEN    = 3'd7;

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic                           wr_s;
  logic [NUM_LEDG-1:0]            led_g_r;
  logic [NUM_LEDR-1:0]            led_r_r;
  logic [HEX_W-1:0]               hex_data_r;
  logic [NUM_HEX-1:0]             hex_blank_r;
  logic [7*NUM_HEX-1:0]           hex_next_s;
  logic [7*NUM_HEX-1:0]           hex_n_r;
  logic [NUM_KEYS-1:0]            key_sync1_r;
  logic [NUM_KEYS-1:0]            key_sync2_r;
  logic [NUM_KEYS-1:0]            key_lvl_s;
  logic [NUM_KEYS-1:0]            key_deb_r;
  logic [NUM_KEYS-1:0]            key_deb_next_s;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_r;
  logic [NUM_KEYS-1:0][CNT_W-1:0] cnt_next_s;
  logic [NUM_SW-1:0]              sw_sync1_r;
  logic [NUM_SW-1:0]              sw_sync2_r;
  logic [NUM_KEYS-1:0]            event_s;
  logic [NUM_KEYS-1:0]            irq_en_s;
  logic                           unused_s;

  assign ack      = stb;
  assign wr_s     = stb & we;
  assign led_g    = led_g_r;
  assign led_r    = led_r_r;
  assign hex_n    = hex_n_r;
  assign unused_s = ^data_in;

  // Bus-writable LED and display registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_g_r     <= {NUM_LEDG{1'b0}};
      led_r_r     <= {NUM_LEDR{1'b0}};
      hex_data_r  <= {HEX_W{1'b0}};
      hex_blank_r <= {NUM_HEX{1'b1}};
    end else if (wr_s) begin
      case (addr)
        A_LEDG:     led_g_r     <= data_in[NUM_LEDG-1:0];
        A_LEDR:     led_r_r     <= data_in[NUM_LEDR-1:0];
        A_HEXDATA:  hex_data_r  <= data_in[HEX_W-1:0];
        A_HEXBLANK: hex_blank_r <= data_in[NUM_HEX-1:0];
        default:    ;
      endcase
    end
  end

  // Per-digit glyph selection with blanking
  always_comb begin
    hex_next_s = {(7*NUM_HEX){1'b1}};
    for (int i = 0; i < NUM_HEX; i++) begin
      if (hex_blank_r[i]) begin
        hex_next_s[7*i +: 7] = 7'b1111111;
      end else begin
        hex_next_s[7*i +: 7] = seg7(hex_data_r[4*i +: 4]);
      end
    end
  end

  // Registered segment drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_n_r <= {(7*NUM_HEX){1'b1}};
    end else begin
      hex_n_r <= hex_next_s;
    end
  end

  // Two-flop synchronisers; key flops park at the released (high) level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync1_r <= {NUM_KEYS{1'b1}};
      key_sync2_r <= {NUM_KEYS{1'b1}};
      sw_sync1_r  <= {NUM_SW{1'b0}};
      sw_sync2_r  <= {NUM_SW{1'b0}};
    end else begin
      key_sync1_r <= key_n;
      key_sync2_r <= key_sync1_r;
      sw_sync1_r  <= sw;
      sw_sync2_r  <= sw_sync1_r;
    end
  end

  assign key_lvl_s = ~key_sync2_r;

  // Debounce: count consecutive disagreeing cycles, accept the new level at the terminal count
  always_comb begin
    key_deb_next_s = key_deb_r;
    cnt_next_s     = {(NUM_KEYS*CNT_W){1'b0}};
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (key_lvl_s[k] == key_deb_r[k]) begin
        cnt_next_s[k] = {CNT_W{1'b0}};
      end else if (cnt_r[k] == CNT_LAST) begin
        key_deb_next_s[k] = ~key_deb_r[k];
        cnt_next_s[k]     = {CNT_W{1'b0}};
      end else begin
        cnt_next_s[k] = cnt_r[k] + CNT_W'(1'b1);
      end
    end
  end

  // Debounce state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_deb_r <= {NUM_KEYS{1'b0}};
      cnt_r     <= {(NUM_KEYS*CNT_W){1'b0}};
    end else begin
      key_deb_r <= key_deb_next_s;
      cnt_r     <= cnt_next_s;
    end
  end

`ifdef BIO_GEN_IRQ_EN
  logic [NUM_KEYS-1:0] event_r;
  logic [NUM_KEYS-1:0] irq_en_r;
  logic [NUM_KEYS-1:0] key_rise_s;
  logic [NUM_KEYS-1:0] event_clr_s;
  logic                irq_r;

  assign key_rise_s  = key_deb_next_s & ~key_deb_r;
  assign event_clr_s = (wr_s && (addr == A_EVENT)) ? data_in[NUM_KEYS-1:0] : {NUM_KEYS{1'b0}};

  // Sticky press events (a new press outranks a same-cycle clear), enables, interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      event_r  <= {NUM_KEYS{1'b0}};
      irq_en_r <= {NUM_KEYS{1'b0}};
      irq_r    <= 1'b0;
    end else begin
      event_r <= (event_r & ~event_clr_s) | key_rise_s;
      if (wr_s && (addr == A_IRQEN)) begin
        irq_en_r <= data_in[NUM_KEYS-1:0];
      end
      irq_r <= |(event_r & irq_en_r);
    end
  end

  assign event_s  = event_r;
  assign irq_en_s = irq_en_r;
  assign irq      = irq_r;
`else
  assign event_s  = {NUM_KEYS{1'b0}};
  assign irq_en_s = {NUM_KEYS{1'b0}};
  assign irq      = 1'b0;
`endif

  // Read-data multiplexer, zero-extended
  always_comb begin
    data_out = 32'h0000_0000;
    case (addr)
      A_LEDG:     data_out = 32'(led_g_r);
      A_LEDR:     data_out = 32'(led_r_r);
      A_HEXDATA:  data_out = 32'(hex_data_r);
      A_HEXBLANK: data_out = 32'(hex_blank_r);
      A_KEYS:     data_out = 32'(key_deb_r);
      A_SW:       data_out = 32'(sw_sync2_r);
      A_EVENT:    data_out = 32'(event_s);
      A_IRQEN:    data_out = 32'(irq_en_s);
      default:    data_out = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_bio_gen.sv
// Self-checking bench for bio_gen: randomized stimulus against a timestamp-based behavioural model.
`timescale 1ns/1ps
module tb_bio_gen;

  localparam int NK  = 3;
  localparam int NSW = 18;
  localparam int NLG = 9;
  localparam int NLR = 18;
  localparam int NH  = 8;
  localparam int DB  = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stb = 1'b0;
  logic            we = 1'b0;
  logic [2:0]      addr = 3'd0;
  logic [31:0]     data_in = 32'd0;
  logic [31:0]     data_out;
  logic            ack;
  logic            irq;
  logic [NLG-1:0]  led_g;
  logic [NLR-1:0]  led_r;
  logic [7*NH-1:0] hex_n;
  logic [NK-1:0]   key_n = {NK{1'b1}};
  logic [NSW-1:0]  sw = {NSW{1'b0}};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bio_gen #(
    .NUM_KEYS(NK), .NUM_SW(NSW), .NUM_LEDG(NLG), .NUM_LEDR(NLR),
    .NUM_HEX(NH), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stb(stb), .we(we), .addr(addr),
    .data_in(data_in), .data_out(data_out), .ack(ack), .irq(irq),
    .led_g(led_g), .led_r(led_r), .hex_n(hex_n), .key_n(key_n), .sw(sw)
  );

  // Segments lit for each hex glyph
  string segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                       "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] on;
    string s;
    on = 7'b0;
    s = segs[v];
    for (int i = 0; i < s.len(); i++) on[int'(s[i]) - 97] = 1'b1;
    return ~on;
  endfunction

  function automatic logic [7*NH-1:0] exp_hex(input logic [31:0] dat, input logic [NH-1:0] blank);
    logic [7*NH-1:0] r;
    for (int i = 0; i < NH; i++) r[7*i +: 7] = blank[i] ? 7'h7F : glyph(dat[4*i +: 4]);
    return r;
  endfunction

  // Reference model: a key level is accepted once it has been stable DB cycles past the synchroniser
  int            cyc = 0;
  logic [NK-1:0] m_kp1, m_kp2, m_keys;
  int            m_chg [NK];
  logic [NSW-1:0] m_sp1, m_sw;
  logic [NK-1:0] m_event, m_irqen;
  logic          m_irq;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kp1 <= '0; m_kp2 <= '0; m_keys <= '0; m_sp1 <= '0; m_sw <= '0;
      m_event <= '0; m_irqen <= '0; m_irq <= 1'b0;
      for (int k = 0; k < NK; k++) m_chg[k] <= 0;
    end else begin
      m_kp1 <= ~key_n;
      m_kp2 <= m_kp1;
      m_sp1 <= sw;
      m_sw  <= m_sp1;
      for (int k = 0; k < NK; k++) begin
        if (m_kp1[k] != m_kp2[k]) m_chg[k] <= cyc;
        if (m_kp2[k] != m_keys[k] && cyc - m_chg[k] >= DB) m_keys[k] <= m_kp2[k];
        if (m_kp2[k] && !m_keys[k] && cyc - m_chg[k] >= DB) m_event[k] <= 1'b1;
        else if (stb && we && addr == 3'd6 && data_in[k]) m_event[k] <= 1'b0;
      end
      if (stb && we && addr == 3'd7) m_irqen <= data_in[NK-1:0];
      m_irq <= |(m_event & m_irqen);
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clk);
    #1;
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic a_ack);
    stb = 1'b1; we = 1'b0; addr = a;
    #1;
    d = data_out; a_ack = ack;
    stb = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        k;
    logic [31:0] exp_rst [6] = '{32'h0, 32'h0, 32'h0, 32'hFF, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    checks++;
    if (hex_n !== {(7*NH){1'b1}} || led_g !== '0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: hex_n=%h led_g=%h irq=%b, required all-ones/0/0", hex_n, led_g, irq);
    end
    rst_n = 1'b1;
    #1;
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), d, k);
      checks++;
      if (d !== exp_rst[a] || k !== 1'b1) begin
        errors++; $display("FAIL reset_read%0d: got %h ack %b, required %h ack 1", a, d, k, exp_rst[a]);
      end
    end
    #1;
    checks++;
    if (ack !== 1'b0) begin errors++; $display("FAIL ack_idle: got %b, required 0", ack); end
  endtask

  task automatic test_leds();
    logic [31:0] d, v, w;
    logic        k;
    bus_write(3'd0, 32'h1A5);
    bus_read(3'd0, d, k);
    checks++;
    if (d !== 32'h1A5 || led_g !== 9'h1A5) begin
      errors++; $display("FAIL ledg_plan: read %h pins %h, required 1a5", d, led_g);
    end
    for (int i = 0; i < 4; i++) begin
      v = $urandom; w = $urandom;
      bus_write(3'd0, v);
      bus_write(3'd1, w);
      bus_read(3'd0, d, k);
      checks++;
      if (d !== (v & 32'h1FF) || led_g !== v[NLG-1:0]) begin
        errors++; $display("FAIL ledg_rand: read %h pins %h, required %h", d, led_g, v & 32'h1FF);
      end
      bus_read(3'd1, d, k);
      checks++;
      if (d !== (w & 32'h3FFFF) || led_r !== w[NLR-1:0]) begin
        errors++; $display("FAIL ledr_rand: read %h pins %h, required %h", d, led_r, w & 32'h3FFFF);
      end
    end
    bus_write(3'd4, 32'hFFFF_FFFF);
    bus_read(3'd4, d, k);
    checks++;
    if (d !== 32'({NK{1'b0}} | m_keys)) begin errors++; $display("FAIL keys_ro: got %h, required %h", d, m_keys); end
  endtask

  task automatic test_hex();
    logic [31:0] d, v;
    logic [NH-1:0] b;
    logic        k;
    bus_write(3'd2, 32'h7654_3210);
    bus_write(3'd3, 32'h0);
    checks++;
    if (hex_n !== {(7*NH){1'b1}}) begin errors++; $display("FAIL hex_latency: got %h, required all ones", hex_n); end
    @(posedge clk); #1;
    checks++;
    if (hex_n[6:0] !== 7'b1000000 || hex_n[55:49] !== 7'b1111000) begin
      errors++; $display("FAIL hex_plan: digit0 %b digit7 %b, required 1000000 1111000", hex_n[6:0], hex_n[55:49]);
    end
    checks++;
    if (hex_n !== exp_hex(32'h7654_3210, 8'h00)) begin
      errors++; $display("FAIL hex_plan_all: got %h, required %h", hex_n, exp_hex(32'h7654_3210, 8'h00));
    end
    for (int i = 0; i < 5; i++) begin
      v = $urandom; b = 8'($urandom);
      bus_write(3'd2, v);
      bus_write(3'd3, 32'(b));
      @(posedge clk); #1;
      checks++;
      if (hex_n !== exp_hex(v, b)) begin
        errors++; $display("FAIL hex_rand: got %h, required %h", hex_n, exp_hex(v, b));
      end
      bus_read(3'd3, d, k);
      checks++;
      if (d !== 32'(b)) begin errors++; $display("FAIL hexblank_read: got %h, required %h", d, b); end
    end
  endtask

  task automatic test_switch();
    logic [31:0] d;
    logic [NSW-1:0] prev, v;
    logic        k;
    prev = '0;
    v = 18'h2AAAA;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sw = v;
      @(posedge clk); #1;
      bus_read(3'd5, d, k);
      checks++;
      if (d !== 32'(prev)) begin errors++; $display("FAIL sw_early: got %h, required %h", d, prev); end
      @(posedge clk); #1;
      bus_read(3'd5, d, k);
      checks++;
      if (d !== 32'(v) || d !== 32'(m_sw)) begin errors++; $display("FAIL sw_sync: got %h, required %h", d, v); end
      prev = v;
      v = NSW'($urandom);
    end
  endtask

  task automatic test_key_glitch();
    logic [31:0] d;
    logic        k;
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (DB - 2) @(negedge clk);
    key_n[0] = 1'b1;
    for (int i = 0; i < DB + 6; i++) begin
      @(posedge clk); #1;
      bus_read(3'd4, d, k);
      checks++;
      if (d !== 32'h0 || d !== 32'(m_keys)) begin errors++; $display("FAIL key_glitch: got %h, required 0", d); end
    end
  endtask

  task automatic test_key_press();
    logic [31:0] d;
    logic        k;
    @(negedge clk);
    key_n[0] = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      bus_read(3'd4, d, k);
      checks++;
      if (d !== ((n >= DB + 2) ? 32'h1 : 32'h0)) begin
        errors++; $display("FAIL key_latency: edge %0d got %h, required %h", n, d, (n >= DB + 2) ? 1 : 0);
      end
    end
    @(negedge clk);
    key_n[0] = 1'b1;
    repeat (DB + 4) @(posedge clk);
    #1;
    bus_read(3'd4, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL key_release: got %h, required 0", d); end
  endtask

  task automatic test_key_random();
    logic [31:0] d;
    logic        k;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) key_n[$urandom_range(0, NK - 1)] ^= 1'b1;
      @(posedge clk); #1;
      bus_read(3'd4, d, k);
      checks++;
      if (d !== 32'(m_keys)) begin errors++; $display("FAIL key_rand: cycle %0d got %h, required %h", i, d, m_keys); end
    end
    @(negedge clk);
    key_n = {NK{1'b1}};
    repeat (DB + 4) @(posedge clk);
    #1;
    bus_read(3'd4, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL key_rand_release: got %h, required 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        k;
    @(negedge clk);
    key_n[1] = 1'b0;
    repeat (DB - 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    bus_read(3'd4, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mid: got %h, required 0", d); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (DB) @(posedge clk);
    #1;
    bus_read(3'd4, d, k);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_mid_restart: got %h, required 0", d); end
    repeat (4) @(posedge clk);
    #1;
    bus_read(3'd4, d, k);
    checks++;
    if (d !== 32'h2 || d !== 32'(m_keys)) begin errors++; $display("FAIL reset_mid_held: got %h, required 2", d); end
    @(negedge clk);
    key_n[1] = 1'b1;
    repeat (DB + 4) @(posedge clk);
  endtask

`ifdef BIO_GEN_IRQ_EN
  task automatic test_irq();
    logic [31:0] d;
    logic        k;
    bus_write(3'd6, 32'h7);
    bus_write(3'd7, 32'h1);
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (DB + 2) @(posedge clk);
    #1;
    bus_read(3'd6, d, k);
    checks++;
    if (d !== 32'h1 || irq !== 1'b0) begin errors++; $display("FAIL event_set: event %h irq %b, required 1 0", d, irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1 || irq !== m_irq) begin errors++; $display("FAIL irq_set: got %b, required 1", irq); end
    @(negedge clk);
    key_n[0] = 1'b1;
    repeat (DB + 4) @(posedge clk);
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (DB + 1) @(posedge clk);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; addr = 3'd6; data_in = 32'h1;
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    bus_read(3'd6, d, k);
    checks++;
    if (d !== 32'h1 || d !== 32'(m_event) || irq !== 1'b1) begin
      errors++; $display("FAIL event_set_wins: event %h irq %b, required 1 1", d, irq);
    end
    bus_write(3'd6, 32'h1);
    bus_read(3'd6, d, k);
    checks++;
    if (d !== 32'h0 || irq !== 1'b1) begin errors++; $display("FAIL event_clear: event %h irq %b, required 0 1", d, irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0 || irq !== m_irq) begin errors++; $display("FAIL irq_drop: got %b, required 0", irq); end
    @(negedge clk);
    key_n = 3'b101;
    repeat (DB + 4) @(posedge clk);
    #1;
    bus_read(3'd6, d, k);
    checks++;
    if (d !== 32'h2 || irq !== 1'b0 || d !== 32'(m_event)) begin
      errors++; $display("FAIL event_masked: event %h irq %b, required 2 0", d, irq);
    end
    @(negedge clk);
    key_n = {NK{1'b1}};
    repeat (DB + 4) @(posedge clk);
  endtask
`else
  task automatic test_irq();
    logic [31:0] d;
    logic        k;
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_write(3'd7, 32'hFFFF_FFFF);
    for (int a = 6; a < 8; a++) begin
      bus_read(3'(a), d, k);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read%0d: got %h, required 0", a, d); end
    end
    @(negedge clk);
    key_n[0] = 1'b0;
    repeat (DB + 4) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_tied: got %b, required 0", irq); end
    @(negedge clk);
    key_n[0] = 1'b1;
    repeat (DB + 4) @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_leds();
    test_hex();
    test_switch();
    test_key_glitch();
    test_key_press();
    test_key_random();
    test_reset_mid();
    test_irq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
